// File: rtl/mxrv_csr_ctrl_pkg.sv
// Shared definitions for the CSR sequencer: bus widths, FSM states, Zicsr funct3 codes
// and the machine-mode CSR addresses used by the trap and MRET sequences.
package mxrv_csr_ctrl_pkg;

    localparam int RegBus        = 32;
    localparam int CsrRegAddrBus = 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_C_RD,
        S_C_WR,
        S_T_EPC,
        S_T_CAUSE,
        S_T_VAL,
        S_T_VEC,
        S_T_JMP,
        S_M_RD,
        S_M_JMP
    } state_t;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [CsrRegAddrBus-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CsrRegAddrBus-1:0] CSR_MIE      = 12'h304;
    localparam logic [CsrRegAddrBus-1:0] CSR_MTVEC    = 12'h305;
    localparam logic [CsrRegAddrBus-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CsrRegAddrBus-1:0] CSR_MEPC     = 12'h341;
    localparam logic [CsrRegAddrBus-1:0] CSR_MCAUSE   = 12'h342;
    localparam logic [CsrRegAddrBus-1:0] CSR_MTVAL    = 12'h343;

    localparam logic Write = 1'b1;
    localparam logic Read  = 1'b0;

endpackage

// File: rtl/mxrv_csr_ctrl_alu.sv
// Combinational Zicsr read-modify-write: new CSR value and whether the write happens.
module mxrv_csr_alu
    import mxrv_csr_ctrl_pkg::*;
(
    input  logic [RegBus-1:0] old_val,
    input  logic [RegBus-1:0] src_val,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1_idx,
    output logic [RegBus-1:0] new_val,
    output logic              write_en
);

    // Set/clear with rs1 (or zimm) index zero are pure reads.
    always_comb begin
        new_val  = old_val;
        write_en = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                new_val  = src_val;
                write_en = 1'b1;
            end
            2'b10: begin
                new_val  = old_val | src_val;
                write_en = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_val  = old_val & ~src_val;
                write_en = (rs1_idx != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mxrv_csr_ctrl.sv
// CSR port sequencer: arbitrates traps, MRET and Zicsr instructions onto one
// synchronous-read CSR register port and issues PC redirects.
module mxrv_csr_ctrl
    import mxrv_csr_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     csr_req_i,
    input  logic [2:0]               csr_funct3_i,
    input  logic [CsrRegAddrBus-1:0] csr_addr_i,
    input  logic [4:0]               csr_rs1_idx_i,
    input  logic [RegBus-1:0]        csr_rs1_data_i,
    output logic                     csr_ack_o,
    input  logic                     trap_req_i,
    input  logic [RegBus-1:0]        trap_pc_i,
    input  logic [RegBus-1:0]        trap_cause_i,
    input  logic [RegBus-1:0]        trap_val_i,
    input  logic                     mret_req_i,
    output logic                     done_o,
    output logic                     rd_we_o,
    output logic [RegBus-1:0]        rd_wdata_o,
    output logic                     illegal_o,
    output logic                     redirect_o,
    output logic [RegBus-1:0]        redirect_pc_o,
    output logic                     busy_o,
    output logic [CsrRegAddrBus-1:0] csr_addr_o,
    output logic                     csr_we_o,
    output logic [RegBus-1:0]        csr_wdata_o,
    input  logic [RegBus-1:0]        csr_rdata_i
);

    state_t                   state, state_next;
    logic                     take_trap, take_csr;
    logic [2:0]               funct3_q;
    logic [CsrRegAddrBus-1:0] addr_q;
    logic [4:0]               idx_q;
    logic [RegBus-1:0]        data_q, pc_q, cause_q, val_q;
    logic [RegBus-1:0]        src_val, new_val;
    logic                     alu_we;

    assign src_val = funct3_q[2] ? {{(RegBus-5){1'b0}}, idx_q} : data_q;

    mxrv_csr_alu u_alu (
        .old_val  (csr_rdata_i),
        .src_val  (src_val),
        .funct3   (funct3_q),
        .rs1_idx  (idx_q),
        .new_val  (new_val),
        .write_en (alu_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            funct3_q <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            pc_q     <= '0;
            cause_q  <= '0;
            val_q    <= '0;
        end else begin
            state <= state_next;
            if (take_trap) begin
                pc_q    <= trap_pc_i;
                cause_q <= trap_cause_i;
                val_q   <= trap_val_i;
            end
            if (take_csr) begin
                funct3_q <= csr_funct3_i;
                addr_q   <= csr_addr_i;
                idx_q    <= csr_rs1_idx_i;
                data_q   <= csr_rs1_data_i;
            end
        end
    end

    // Port read data arrives one cycle after the read slot, so the C_WR, T_JMP and
    // M_JMP slots consume csr_rdata_i directly.
    always_comb begin
        state_next    = state;
        take_trap     = 1'b0;
        take_csr      = 1'b0;
        csr_ack_o     = 1'b0;
        done_o        = 1'b0;
        rd_we_o       = 1'b0;
        rd_wdata_o    = '0;
        illegal_o     = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        csr_addr_o    = '0;
        csr_we_o      = Read;
        csr_wdata_o   = '0;
        busy_o        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (trap_req_i) begin
                    csr_ack_o  = 1'b1;
                    take_trap  = 1'b1;
                    state_next = S_T_EPC;
                end else if (mret_req_i) begin
                    csr_ack_o  = 1'b1;
                    state_next = S_M_RD;
                end else if (csr_req_i) begin
                    csr_ack_o  = 1'b1;
                    take_csr   = 1'b1;
                    state_next = S_C_RD;
                end
            end
            S_C_RD: begin
                if (funct3_q[1:0] == 2'b00) begin
                    done_o     = 1'b1;
                    illegal_o  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    csr_addr_o = addr_q;
                    state_next = S_C_WR;
                end
            end
            S_C_WR: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
                if (alu_we && addr_q[11:10] == 2'b11) begin
                    illegal_o = 1'b1;
                end else begin
                    rd_we_o    = 1'b1;
                    rd_wdata_o = csr_rdata_i;
                    if (alu_we) begin
                        csr_addr_o  = addr_q;
                        csr_we_o    = Write;
                        csr_wdata_o = new_val;
                    end
                end
            end
            S_T_EPC: begin
                csr_addr_o  = CSR_MEPC;
                csr_we_o    = Write;
                csr_wdata_o = pc_q;
                state_next  = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr_o  = CSR_MCAUSE;
                csr_we_o    = Write;
                csr_wdata_o = cause_q;
                state_next  = S_T_VAL;
            end
            S_T_VAL: begin
                csr_addr_o  = CSR_MTVAL;
                csr_we_o    = Write;
                csr_wdata_o = val_q;
                state_next  = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr_o = CSR_MTVEC;
                state_next = S_T_JMP;
            end
            S_T_JMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = {csr_rdata_i[RegBus-1:2], 2'b00};
                state_next    = S_IDLE;
            end
            S_M_RD: begin
                csr_addr_o = CSR_MEPC;
                state_next = S_M_JMP;
            end
            S_M_JMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = csr_rdata_i;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mxrv_csr_ctrl.sv
// Scoreboard bench for mxrv_csr_ctrl with a behavioural CSR file model and a
// simple synchronous-read CSR register standing in for mxrv_csr_reg.
module tb_mxrv_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req = 1'b0;
    logic [2:0]  csr_funct3 = '0;
    logic [11:0] csr_addr = '0;
    logic [4:0]  csr_rs1_idx = '0;
    logic [31:0] csr_rs1_data = '0;
    logic        csr_ack;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0, trap_cause = '0, trap_val = '0;
    logic        mret_req = 1'b0;
    logic        done, rd_we, illegal, redirect, busy, csr_we;
    logic [31:0] rd_wdata, redirect_pc, csr_wdata;
    logic [11:0] csr_addr_port;
    logic [31:0] csr_rdata = '0;

    mxrv_csr_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req_i      (csr_req),
        .csr_funct3_i   (csr_funct3),
        .csr_addr_i     (csr_addr),
        .csr_rs1_idx_i  (csr_rs1_idx),
        .csr_rs1_data_i (csr_rs1_data),
        .csr_ack_o      (csr_ack),
        .trap_req_i     (trap_req),
        .trap_pc_i      (trap_pc),
        .trap_cause_i   (trap_cause),
        .trap_val_i     (trap_val),
        .mret_req_i     (mret_req),
        .done_o         (done),
        .rd_we_o        (rd_we),
        .rd_wdata_o     (rd_wdata),
        .illegal_o      (illegal),
        .redirect_o     (redirect),
        .redirect_pc_o  (redirect_pc),
        .busy_o         (busy),
        .csr_addr_o     (csr_addr_port),
        .csr_we_o       (csr_we),
        .csr_wdata_o    (csr_wdata),
        .csr_rdata_i    (csr_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Stand-in CSR register file: write on the edge, registered read.
    bit [31:0] env_mem [0:4095];
    always @(posedge clk) begin
        if (csr_we) env_mem[csr_addr_port] <= csr_wdata;
        csr_rdata <= env_mem[csr_addr_port];
    end

    typedef struct { logic illegal; logic rd_we; logic [31:0] rd_data; int lat; } done_t;
    typedef struct { logic [11:0] addr; logic [31:0] data; int lat; } wr_t;
    typedef struct { logic [31:0] pc; int lat; } redir_t;

    done_t  done_q[$];
    wr_t    wr_q[$];
    redir_t redir_q[$];
    bit [31:0] ref_csr [0:4095];

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event expected=none (cycle %0d)", name, cycle);
    endtask

    // Monitor: compares every completion, write slot and redirect against the scoreboard.
    int last_ack = 0;
    done_t  d_item;
    wr_t    w_item;
    redir_t r_item;
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_ack) last_ack = cycle;
            if (done) begin
                if (done_q.size() == 0) report_unexpected("unexpected_done");
                else begin
                    d_item = done_q.pop_front();
                    check_output("done_latency", 32'(cycle - last_ack), 32'(d_item.lat));
                    check_output("illegal", 32'(illegal), 32'(d_item.illegal));
                    check_output("rd_we", 32'(rd_we), 32'(d_item.rd_we));
                    if (d_item.rd_we) check_output("rd_wdata", rd_wdata, d_item.rd_data);
                end
            end
            if (csr_we) begin
                if (wr_q.size() == 0) report_unexpected("unexpected_write");
                else begin
                    w_item = wr_q.pop_front();
                    check_output("write_latency", 32'(cycle - last_ack), 32'(w_item.lat));
                    check_output("write_addr", 32'(csr_addr_port), 32'(w_item.addr));
                    check_output("write_data", csr_wdata, w_item.data);
                end
            end
            if (redirect) begin
                if (redir_q.size() == 0) report_unexpected("unexpected_redirect");
                else begin
                    r_item = redir_q.pop_front();
                    check_output("redirect_latency", 32'(cycle - last_ack), 32'(r_item.lat));
                    check_output("redirect_pc", redirect_pc, r_item.pc);
                end
            end
        end
    end

    // Reference behaviour of one Zicsr instruction on the architectural CSR file.
    task automatic model_csr(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [4:0] idx, input logic [31:0] data);
        logic [31:0] old_v, src, new_v;
        bit          writes;
        old_v  = ref_csr[addr];
        src    = f3[2] ? 32'(idx) : data;
        writes = (f3[1:0] == 2'd1) || (idx != 5'd0);
        case (f3[1:0])
            2'd1:    new_v = src;
            2'd2:    new_v = old_v | src;
            default: new_v = old_v & ~src;
        endcase
        if (f3[1:0] == 2'd0) begin
            done_q.push_back('{1'b1, 1'b0, 32'h0, 1});
        end else if (writes && addr[11:10] == 2'b11) begin
            done_q.push_back('{1'b1, 1'b0, 32'h0, 2});
        end else begin
            done_q.push_back('{1'b0, 1'b1, old_v, 2});
            if (writes) begin
                wr_q.push_back('{addr, new_v, 2});
                ref_csr[addr] = new_v;
            end
        end
    endtask

    task automatic model_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] val);
        wr_q.push_back('{12'h341, pc, 1});
        wr_q.push_back('{12'h342, cause, 2});
        wr_q.push_back('{12'h343, val, 3});
        ref_csr[12'h341] = pc;
        ref_csr[12'h342] = cause;
        ref_csr[12'h343] = val;
        redir_q.push_back('{ref_csr[12'h305] & 32'hFFFF_FFFC, 5});
    endtask

    task automatic wait_ack(output int at);
        bit got = 0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (csr_ack) begin
                got = 1;
                at = cycle;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL ack_timeout actual=none expected=ack within 40 cycles");
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) report_unexpected("busy_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_csr(input logic [2:0] f3, input logic [11:0] addr,
                                      input logic [4:0] idx, input logic [31:0] data);
        int at;
        model_csr(f3, addr, idx, data);
        csr_funct3 = f3; csr_addr = addr; csr_rs1_idx = idx; csr_rs1_data = data;
        csr_req = 1'b1;
        wait_ack(at);
        csr_req = 1'b0;
        wait_idle();
    endtask

    task automatic apply_stimulus_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] val);
        int at;
        model_trap(pc, cause, val);
        trap_pc = pc; trap_cause = cause; trap_val = val;
        trap_req = 1'b1;
        wait_ack(at);
        trap_req = 1'b0;
        wait_idle();
    endtask

    task automatic apply_stimulus_mret();
        int at;
        redir_q.push_back('{ref_csr[12'h341], 2});
        mret_req = 1'b1;
        wait_ack(at);
        mret_req = 1'b0;
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_output({tag, "_pulses"}, 32'({csr_ack, done, rd_we, illegal, redirect, busy, csr_we}), 32'h0);
        check_output({tag, "_csr_addr"}, 32'(csr_addr_port), 32'h0);
        check_output({tag, "_csr_wdata"}, csr_wdata, 32'h0);
        check_output({tag, "_rd_wdata"}, rd_wdata, 32'h0);
        check_output({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    endtask

    initial begin
        int at1, at2;
        logic [11:0] addrs [7];
        addrs = '{12'h300, 12'h304, 12'h340, 12'h341, 12'h305, 12'hF11, 12'hC00};

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus_csr(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF);
        apply_stimulus_csr(3'b010, 12'h340, 5'd0, 32'h0);
        apply_stimulus_csr(3'b010, 12'h300, 5'd0, 32'h1234);
        apply_stimulus_csr(3'b001, 12'h304, 5'd1, 32'h888);
        apply_stimulus_csr(3'b111, 12'h304, 5'd8, 32'hFFFF_FFFF);
        apply_stimulus_csr(3'b010, 12'h304, 5'd0, 32'h0);

        apply_stimulus_csr(3'b001, 12'h305, 5'd2, 32'h203);
        apply_stimulus_trap(32'h100, 32'h2, 32'h13);
        apply_stimulus_mret();

        // Trap and CSR raised together: trap wins, CSR is taken once the trap finishes.
        model_trap(32'h400, 32'h7, 32'h55);
        model_csr(3'b010, 12'h340, 5'd3, 32'h0F);
        trap_pc = 32'h400; trap_cause = 32'h7; trap_val = 32'h55;
        csr_funct3 = 3'b010; csr_addr = 12'h340; csr_rs1_idx = 5'd3; csr_rs1_data = 32'h0F;
        trap_req = 1'b1;
        csr_req  = 1'b1;
        wait_ack(at1);
        trap_req = 1'b0;
        wait_ack(at2);
        csr_req = 1'b0;
        check_output("ack_gap_ge6", 32'(at2 - at1 >= 6), 32'd1);
        wait_idle();

        apply_stimulus_csr(3'b001, 12'hF11, 5'd4, 32'h1);
        apply_stimulus_csr(3'b000, 12'h340, 5'd1, 32'h1);
        apply_stimulus_csr(3'b100, 12'h340, 5'd1, 32'h1);
        apply_stimulus_csr(3'b110, 12'hF11, 5'd0, 32'h0);

        // Reset during T_CAUSE: only mepc gets written, no redirect follows.
        wr_q.push_back('{12'h341, 32'h0000_0A00, 1});
        ref_csr[12'h341] = 32'h0000_0A00;
        trap_pc = 32'h0000_0A00; trap_cause = 32'hBAD; trap_val = 32'h77;
        trap_req = 1'b1;
        wait_ack(at1);
        trap_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        apply_stimulus_csr(3'b010, 12'h341, 5'd0, 32'h0);
        apply_stimulus_csr(3'b010, 12'h342, 5'd0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                apply_stimulus_trap($urandom, $urandom, $urandom);
            end else if (kind == 1) begin
                apply_stimulus_mret();
            end else begin
                apply_stimulus_csr(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 6)],
                                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                   $urandom);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check_output("queues_drained", 32'(done_q.size() + wr_q.size() + redir_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
